// File: rtl/mux_n_sync_pkg.sv
// Shared types and defaults for the registered N-channel display multiplexer.
package mux_pkg;

    // Operating mode as presented on the mode input; MODE_RSV acts like MODE_HOLD.
    typedef enum logic [1:0] {
        MODE_MANUAL = 2'd0,
        MODE_SCAN   = 2'd1,
        MODE_HOLD   = 2'd2,
        MODE_RSV    = 2'd3
    } mux_mode_e;

    // One second of dwell per channel at a 50 MHz board clock.
    localparam int unsigned DEFAULT_DWELL = 50_000_000;

endpackage

// File: rtl/mux_n_sync_dwell_counter.sv
// Dwell timer for scan mode: counts enabled cycles and pulses wrap on the last one.
module dwell_counter #(
    parameter int unsigned DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic wrap
);

    localparam int unsigned CNTW = $clog2(DWELL);
    localparam logic [CNTW-1:0] LAST = CNTW'(DWELL - 1);

    logic [CNTW-1:0] cnt;

    assign wrap = en && (cnt == LAST);

    // Clear wins over count; with neither asserted the count is frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mux_n_sync.sv
// Registered N-channel multiplexer with manual select, timed auto-scan and hold.
module mux_n_sync
    import mux_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned N     = 4,
    parameter  int unsigned DWELL = DEFAULT_DWELL,
    localparam int unsigned SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [SELW-1:0]      sel,
    input  logic [1:0]           mode,
    output logic [WIDTH-1:0]     out,
    output logic [SELW-1:0]      out_ch,
    output logic                 step,
    output logic                 sel_err
);

    localparam logic [SELW:0]   N_EXT   = (SELW + 1)'(N);
    localparam logic [SELW-1:0] LAST_CH = SELW'(N - 1);

    mux_mode_e          mode_e;
    logic               is_manual;
    logic               is_scan;
    logic               sel_ok;
    logic               wrap;
    logic               load_out;
    logic               sel_err_d;
    logic [SELW-1:0]    next_ch;
    logic [WIDTH-1:0]   next_data;

    assign mode_e    = mux_mode_e'(mode);
    assign is_manual = (mode_e == MODE_MANUAL);
    assign is_scan   = (mode_e == MODE_SCAN);
    // Extra bit so the range check also works when N is a power of two.
    assign sel_ok    = ({1'b0, sel} < N_EXT);

    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (is_scan),
        .clr   (is_manual),
        .wrap  (wrap)
    );

    // Channel to show after this edge and the select-error flag it implies.
    always_comb begin
        next_ch   = out_ch;
        sel_err_d = sel_err;
        load_out  = 1'b0;
        case (mode_e)
            MODE_MANUAL: begin
                if (sel_ok) begin
                    next_ch   = sel;
                    sel_err_d = 1'b0;
                    load_out  = 1'b1;
                end else begin
                    sel_err_d = 1'b1;
                end
            end
            MODE_SCAN: begin
                sel_err_d = 1'b0;
                load_out  = 1'b1;
                if (wrap) begin
                    next_ch = (out_ch == LAST_CH) ? '0 : out_ch + 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Data of the upcoming channel, so a scan advance shows new data on the same edge.
    always_comb begin
        next_data = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (next_ch == SELW'(k)) begin
                next_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Output registers; step flags any change of the displayed channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out     <= '0;
            out_ch  <= '0;
            step    <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            out_ch  <= next_ch;
            step    <= (next_ch != out_ch);
            sel_err <= sel_err_d;
            if (load_out) begin
                out <= next_data;
            end
        end
    end

endmodule

// File: tb/tb_mux_n_sync.sv
// Directed bench: a 4-channel and a 3-channel instance, both with a dwell of 4 cycles.
module tb_mux_n_sync;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [31:0] in4;
    logic [1:0]  sel4;
    logic [1:0]  mode4;
    logic [7:0]  out4;
    logic [1:0]  ch4;
    logic        step4;
    logic        err4;

    logic [23:0] in3;
    logic [1:0]  sel3;
    logic [1:0]  mode3;
    logic [7:0]  out3;
    logic [1:0]  ch3;
    logic        step3;
    logic        err3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_n_sync #(.WIDTH(8), .N(4), .DWELL(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_data(in4), .sel(sel4), .mode(mode4),
        .out(out4), .out_ch(ch4), .step(step4), .sel_err(err4)
    );

    mux_n_sync #(.WIDTH(8), .N(3), .DWELL(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in3), .sel(sel3), .mode(mode3),
        .out(out3), .out_ch(ch3), .step(step3), .sel_err(err3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk4(input string tag, input logic [7:0] o, input logic [1:0] c, input logic s);
        chk({tag, ".out"}, out4, o);
        chk({tag, ".out_ch"}, ch4, c);
        chk({tag, ".step"}, step4, s);
    endtask

    task automatic chk3(input string tag, input logic [7:0] o, input logic [1:0] c,
                        input logic s, input logic e);
        chk({tag, ".out"}, out3, o);
        chk({tag, ".out_ch"}, ch3, c);
        chk({tag, ".step"}, step3, s);
        chk({tag, ".sel_err"}, err3, e);
    endtask

    initial begin
        rst_n = 1'b0;
        in4   = 32'h44_33_22_11;
        sel4  = 2'd0;
        mode4 = 2'd0;
        in3   = 24'h33_22_11;
        sel3  = 2'd0;
        mode3 = 2'd0;

        // Reset state
        @(negedge clk);
        cyc();
        chk4("rst4", 8'h00, 2'd0, 1'b0);
        chk("rst4.sel_err", err4, 1'b0);
        chk3("rst3", 8'h00, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc();
        chk4("rel4", 8'h11, 2'd0, 1'b0);

        // Manual select, then repeated select gives no pulse
        sel4 = 2'd2;
        cyc();
        chk4("man_sel2", 8'h33, 2'd2, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk4("man_hold", 8'h33, 2'd2, 1'b0);
        end

        // Scan from channel 3 with 3->0 wrap
        sel4 = 2'd3;
        cyc();
        chk4("man_sel3", 8'h44, 2'd3, 1'b1);
        mode4 = 2'd1;
        sel4  = 2'd1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk4("scan_ch3", 8'h44, 2'd3, 1'b0);
        end
        cyc();
        chk4("scan_wrap0", 8'h11, 2'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk4("scan_ch0", 8'h11, 2'd0, 1'b0);
        end
        cyc();
        chk4("scan_to1", 8'h22, 2'd1, 1'b1);

        // Live tracking of channel 1 mid-dwell
        cyc();
        chk4("live_pre", 8'h22, 2'd1, 1'b0);
        in4[15:8] = 8'h5A;
        cyc();
        chk4("live_new", 8'h5A, 2'd1, 1'b0);
        cyc();
        chk4("live_last", 8'h5A, 2'd1, 1'b0);
        cyc();
        chk4("live_adv", 8'h33, 2'd2, 1'b1);
        in4[15:8] = 8'h22;

        // Hold after two counted cycles, then resume
        cyc();
        cyc();
        chk4("hold_pre", 8'h33, 2'd2, 1'b0);
        mode4 = 2'd2;
        in4[23:16] = 8'h77;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk4("hold", 8'h33, 2'd2, 1'b0);
        end
        mode4 = 2'd1;
        cyc();
        chk4("hold_res1", 8'h77, 2'd2, 1'b0);
        cyc();
        chk4("hold_res2", 8'h44, 2'd3, 1'b1);
        in4[23:16] = 8'h33;

        // Reserved mode behaves as hold
        cyc();
        cyc();
        mode4 = 2'd3;
        in4[31:24] = 8'h99;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk4("rsv", 8'h44, 2'd3, 1'b0);
            chk("rsv.sel_err", err4, 1'b0);
        end
        mode4 = 2'd1;
        cyc();
        chk4("rsv_res1", 8'h99, 2'd3, 1'b0);
        cyc();
        chk4("rsv_res2", 8'h11, 2'd0, 1'b1);
        in4[31:24] = 8'h44;

        // Asynchronous reset in the middle of a dwell on channel 1
        for (int i = 0; i < 4; i++) cyc();
        chk4("pre_rst", 8'h22, 2'd1, 1'b1);
        cyc();
        #1 rst_n = 1'b0;
        #1;
        chk4("async_rst", 8'h00, 2'd0, 1'b0);
        @(negedge clk);
        cyc();
        chk4("in_rst", 8'h00, 2'd0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk4("post_rst", 8'h11, 2'd0, 1'b0);
        end
        cyc();
        chk4("post_rst_adv", 8'h22, 2'd1, 1'b1);

        // Three-channel instance: out-of-range select and modulo-3 scan
        sel3 = 2'd1;
        cyc();
        chk3("n3_sel1", 8'h22, 2'd1, 1'b1, 1'b0);
        sel3 = 2'd3;
        cyc();
        chk3("n3_sel3", 8'h22, 2'd1, 1'b0, 1'b1);
        cyc();
        chk3("n3_sel3b", 8'h22, 2'd1, 1'b0, 1'b1);
        mode3 = 2'd2;
        cyc();
        chk3("n3_hold_err", 8'h22, 2'd1, 1'b0, 1'b1);
        mode3 = 2'd0;
        sel3  = 2'd0;
        cyc();
        chk3("n3_sel0", 8'h11, 2'd0, 1'b1, 1'b0);
        sel3 = 2'd2;
        cyc();
        chk3("n3_sel2", 8'h33, 2'd2, 1'b1, 1'b0);
        mode3 = 2'd1;
        sel3  = 2'd3;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk3("n3_scan", 8'h33, 2'd2, 1'b0, 1'b0);
        end
        cyc();
        chk3("n3_wrap", 8'h11, 2'd0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
